// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed hex driver for a common-cathode
// 7-segment array. An internal prescaler paces one digit slot every SCAN_DIV
// clocks. New data is captured into a pending register and moved into the
// displayed shadow only on the frame-wrap tick, so a frame never tears.
// Leading-zero blanking is optional at run time (lzb_en).
// Build option: define SEG_BLINK_EN to add per-digit blinking that toggles
// every BLINK_FRAMES frames (blink_mask selects the digits).
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] show_data,
  input  logic                    load,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              cathodes,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_start
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DB = 4 * NUM_DIGITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0]         r_div_cnt;
  logic [IW-1:0]         r_idx;
  logic [DB-1:0]         r_shadow;
  logic [DB-1:0]         r_pend_data;
  logic                  r_pend;
  logic [6:0]            r_cathodes;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_start;

  logic                  w_tick;
  logic [IW-1:0]         w_nxt;
  logic                  w_frame_tick;
  logic [DB-1:0]         w_shadow_use;
  logic [NUM_DIGITS-1:0] w_hi_zero;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_nib;
  logic                  w_sel_zero;
  logic                  w_blink_off;
  logic                  w_blank;

  // hex nibble to {g,f,e,d,c,b,a}, segments active-high
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_nxt        = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
  assign w_frame_tick = w_tick && (w_nxt == '0);

  // prescaler: one tick per SCAN_DIV clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DW'(1);
  end

  // value the upcoming slot decodes; on the frame-wrap tick the newest data
  // wins (a coincident load bypasses the pending register)
  always_comb begin
    w_shadow_use = r_shadow;
    if (w_frame_tick) begin
      if (load)        w_shadow_use = show_data;
      else if (r_pend) w_shadow_use = r_pend_data;
    end
  end

  // pending capture and frame-boundary transfer into the shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow    <= '0;
      r_pend_data <= '0;
      r_pend      <= 1'b0;
    end else if (w_frame_tick) begin
      r_shadow <= w_shadow_use;
      r_pend   <= 1'b0;
    end else if (load) begin
      r_pend_data <= show_data;
      r_pend      <= 1'b1;
    end
  end

  // w_hi_zero[k]: nibbles k..NUM_DIGITS-1 of the slot's value are all zero
  always_comb begin : p_hi_zero
    logic v_acc;
    v_acc     = 1'b1;
    w_hi_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_acc        = v_acc & (w_shadow_use[4*k +: 4] == 4'h0);
      w_hi_zero[k] = v_acc;
    end
  end

  // select the nibble, blank flag and one-hot enable for digit nxt
  always_comb begin
    w_nib      = 4'h0;
    w_sel_zero = 1'b0;
    w_onehot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_nxt == IW'(k)) begin
        w_nib       = w_shadow_use[4*k +: 4];
        w_sel_zero  = w_hi_zero[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_frm_cnt;
  logic          r_phase_on;
  logic          w_sel_mask;

  // frame counter; phase flips each time it wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frm_cnt  <= '0;
      r_phase_on <= 1'b1;
    end else if (r_frame_start) begin
      if (r_frm_cnt == FRM_LAST) begin
        r_frm_cnt  <= '0;
        r_phase_on <= ~r_phase_on;
      end else begin
        r_frm_cnt <= r_frm_cnt + FW'(1);
      end
    end
  end

  // blink enable of the digit about to be shown
  always_comb begin
    w_sel_mask = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (w_nxt == IW'(k)) w_sel_mask = blink_mask[k];
  end

  assign w_blink_off = ~r_phase_on & w_sel_mask;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blink_off    = 1'b0;
`endif

  // digit 0 is never leading-zero blanked
  assign w_blank = (lzb_en && (w_nxt != '0) && w_sel_zero) || w_blink_off;

  // registered outputs: advance one digit per tick, hold in between
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= IDX_LAST;
      r_an          <= '0;
      r_cathodes    <= 7'h00;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
      if (w_tick) begin
        r_idx      <= w_nxt;
        r_an       <= w_onehot;
        r_cathodes <= w_blank ? 7'h00 : hex7(w_nib);
      end
    end
  end

  assign cathodes    = r_cathodes;
  assign AN          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (NUM_DIGITS=4, SCAN_DIV=4).
module tb_seg_scan_display;

  logic        clk;
  logic        reset;
  logic [15:0] show_data;
  logic        load;
  logic        lzb_en;
  logic [3:0]  blink_mask;
  logic [6:0]  cathodes;
  logic [3:0]  AN;
  logic        frame_start;

  int errs   = 0;
  int checks = 0;

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .show_data(show_data), .load(load),
    .lzb_en(lzb_en), .blink_mask(blink_mask), .cathodes(cathodes),
    .AN(AN), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     data;
    logic            lzb;
    logic [3:0][6:0] exp;   // {digit3, digit2, digit1, digit0}
    logic [6:0]      old2;  // digit2 of the frame in flight when loading
    logic [6:0]      old3;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // advance at negedges until AN shows the wanted digit (bounded)
  task automatic wait_an(input logic [3:0] want);
    int n = 0;
    while (AN !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (AN !== want) chk("wait_an_timeout", {28'b0, AN}, {28'b0, want});
  endtask

  task automatic pulse_load(input logic [15:0] d);
    show_data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [3:0][6:0] exp);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << k;
      wait_an(oh);
      chk({nm, "_an"}, {28'b0, AN}, {28'b0, oh});
      chk({nm, "_seg"}, {25'b0, cathodes}, {25'b0, exp[k]});
    end
  endtask

  // called right after reset release at a negedge, with shadow cleared
  task automatic startup_check(input string nm);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk({nm, "_dark_an"}, {28'b0, AN}, 32'h0);
      chk({nm, "_dark_seg"}, {25'b0, cathodes}, 32'h0);
    end
    @(negedge clk);
    chk({nm, "_first_an"}, {28'b0, AN}, 32'h1);
    chk({nm, "_first_fs"}, {31'b0, frame_start}, 32'h1);
    chk({nm, "_first_seg"}, {25'b0, cathodes}, 32'h3F);
    @(negedge clk);
    chk({nm, "_fs_drop"}, {31'b0, frame_start}, 32'h0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk({nm, "_an1"}, {28'b0, AN}, 32'h2);
    chk({nm, "_an1_fs"}, {31'b0, frame_start}, 32'h0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk({nm, "_an2"}, {28'b0, AN}, 32'h4);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk({nm, "_an3"}, {28'b0, AN}, 32'h8);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk({nm, "_wrap_an"}, {28'b0, AN}, 32'h1);
    chk({nm, "_wrap_fs"}, {31'b0, frame_start}, 32'h1);
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}, 7'h3F, 7'h3F};
    vecs[1] = '{16'h0030, 1'b1, {7'h00, 7'h00, 7'h4F, 7'h3F}, 7'h5B, 7'h06};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 7'h00, 7'h00};
    vecs[3] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 7'h3F, 7'h3F};
    vecs[4] = '{16'h9345, 1'b1, {7'h6F, 7'h4F, 7'h66, 7'h6D}, 7'h00, 7'h00};
    vecs[5] = '{16'h0B7C, 1'b1, {7'h00, 7'h7C, 7'h07, 7'h39}, 7'h4F, 7'h6F};
    vecs[6] = '{16'h0D08, 1'b1, {7'h00, 7'h5E, 7'h3F, 7'h7F}, 7'h7C, 7'h00};
    vecs[7] = '{16'hE006, 1'b0, {7'h79, 7'h3F, 7'h3F, 7'h7D}, 7'h5E, 7'h3F};

    reset = 1'b1; load = 1'b0; show_data = 16'h0; lzb_en = 1'b0; blink_mask = 4'b0;

    // held in reset: dark
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", {28'b0, AN}, 32'h0);
    chk("rst_seg", {25'b0, cathodes}, 32'h0);
    chk("rst_fs", {31'b0, frame_start}, 32'h0);
    reset = 1'b0;
    startup_check("start");

    // table: load mid-frame, old frame untouched, next frame shows new data
    for (int v = 0; v < 8; v++) begin
      wait_an(4'b0001);
      lzb_en = vecs[v].lzb;
      wait_an(4'b0010);
      pulse_load(vecs[v].data);
      wait_an(4'b0100);
      chk($sformatf("v%0d_old2", v), {25'b0, cathodes}, {25'b0, vecs[v].old2});
      wait_an(4'b1000);
      chk($sformatf("v%0d_old3", v), {25'b0, cathodes}, {25'b0, vecs[v].old3});
      check_frame($sformatf("v%0d", v), vecs[v].exp);
    end

    // two loads in one frame: last one wins
    wait_an(4'b0001);
    lzb_en = 1'b0;
    wait_an(4'b0010);
    pulse_load(16'h1111);
    wait_an(4'b0100);
    pulse_load(16'h2222);
    wait_an(4'b1000);
    chk("dbl_old3", {25'b0, cathodes}, 32'h79);
    check_frame("dbl", {4{7'h5B}});

    // load coincident with the frame-wrap tick goes straight to display
    for (int i = 0; i < 3; i++) @(negedge clk);
    show_data = 16'h4444;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    show_data = 16'h7777;
    chk("coin_an", {28'b0, AN}, 32'h1);
    chk("coin_fs", {31'b0, frame_start}, 32'h1);
    chk("coin_seg", {25'b0, cathodes}, 32'h66);
    check_frame("coin_f0", {4{7'h66}});
    wait_an(4'b0001);
    check_frame("coin_f1", {4{7'h66}});

    // reset mid-scan discards a pending load
    wait_an(4'b0001);
    wait_an(4'b0010);
    pulse_load(16'h5555);
    wait_an(4'b0100);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_an", {28'b0, AN}, 32'h0);
    chk("mid_rst_seg", {25'b0, cathodes}, 32'h0);
    chk("mid_rst_fs", {31'b0, frame_start}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    startup_check("restart");
    check_frame("restart_f2", {4{7'h3F}});

    // blink on digit1
    blink_mask = 4'b0010;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      logic [6:0] e1;
`ifdef SEG_BLINK_EN
      e1 = ((f % 4) >= 2) ? 7'h00 : 7'h3F;
`else
      e1 = 7'h3F;
`endif
      wait_an(4'b0001);
      chk($sformatf("blink_f%0d_d0", f), {25'b0, cathodes}, 32'h3F);
      wait_an(4'b0010);
      chk($sformatf("blink_f%0d_d1", f), {25'b0, cathodes}, {25'b0, e1});
      wait_an(4'b0100);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
